d_input_debouncer: RTL
======================

# d_input_debouncer

Input conditioner that sits directly upstream of the asynchronous-reset D flip-flop stage and drives its `d` input. It takes a raw, asynchronous, possibly bouncing level, synchronises it into the `clk` domain, and accepts a level change only after it has been stable for a programmable number of cycles. It presents the accepted level on `d_out`, together with one-cycle `rise` and `fall` pulses and a `busy` flag.

## Interface
- `STABLE_CYCLES`, default 8: consecutive synchronised samples required to accept a change. Legal range is 2 ≤ STABLE_CYCLES ≤ 2**CNT_W − 1.
- `CNT_W`, default 4: width of the stability counter.
- `RESET_VAL`, default 0: level of `d_out` and the synchroniser flops while in reset.
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low. 0 = in reset.
- `din_raw`, input, 1: raw asynchronous level.
- `d_out`, output, 1: debounced level. Feeds the downstream flop's `d`.
- `rise`, output, 1: one-cycle pulse when `d_out` goes 0→1.
- `fall`, output, 1: one-cycle pulse when `d_out` goes 1→0.
- `busy`, output, 1: high while a candidate change is being qualified.

## Operation
- **Synchroniser:** two flops, `s0 <= din_raw` and `s1 <= s0`. `s1` is the only signal the FSM samples.
- **FSM states:**
  - `IDLE_LO`: `d_out` = 0.
  - `CHK_HI`: qualifying a rise.
  - `IDLE_HI`: `d_out` = 1.
  - `CHK_LO`: qualifying a fall.
- **From an `IDLE_x` state:**
  - If `s1` ≠ the current level: go to `CHK_*` and set `cnt <= 1`.
  - Otherwise: stay, with `cnt` = 0.
- **From a `CHK_*` state:**
  - If `s1` equals the candidate level and `cnt == STABLE_CYCLES-1`: commit. `d_out <=` candidate, pulse `rise` or `fall`, go to `IDLE_candidate`, `cnt <= 0`.
  - If `s1` equals the candidate level and `cnt` is below that: `cnt <= cnt+1`.
  - If `s1` does not equal the candidate level: return to the originating `IDLE` state, `cnt <= 0`, no pulse, `d_out` unchanged.
- **Outputs:**
  - `busy` = (state is `CHK_HI` or `CHK_LO`), decoded from registered state.
  - `d_out`, `rise` and `fall` are registered.
  - `rise` and `fall` are never high in the same cycle.
- **Width rule:** `cnt` is unsigned `CNT_W` bits. It never exceeds `STABLE_CYCLES-1`, so it never wraps.

## Timing
- **Reset values, asserted asynchronously:**
  - `s0` = `s1` = `d_out` = `RESET_VAL`.
  - `rise` = `fall` = `busy` = 0.
  - `cnt` = 0.
  - state = `IDLE_LO` if `RESET_VAL` = 0, else `IDLE_HI`.
- **Reset deassertion:** first active edge is the first rising `clk` after `reset` goes high. No pulse is emitted coming out of reset.
- **Latency:**
  - Edge 1 is the first rising edge after a clean `din_raw` change.
  - `s1` changes after edge 2 and is first seen by the FSM at edge 3.
  - `d_out`, `rise` or `fall` change after edge `STABLE_CYCLES+2`.
  - The pulse lasts exactly one cycle.
- **Mismatch during qualification:** a single differing `s1` sample in `CHK_*` restarts qualification from zero. Glitches shorter than `STABLE_CYCLES` cycles never reach `d_out`.
- **Return during qualification:** if `din_raw` returns to the original level mid-qualification, the block is back in `IDLE` one edge after `s1` reverts, with `busy` low.
- **Reset mid-qualification:** the block abandons the candidate, takes reset values immediately, and emits no pulse.
- **Simultaneous events:** a commit edge and an `s1` change on the same edge resolve as commit. The new `s1` value is evaluated from the new `IDLE` state on the next edge.

## Structure
- **Package `debounce_pkg`:**
  - state typedef `dbnc_state_t`, 2-bit encoding: `IDLE_LO`=00, `CHK_HI`=01, `IDLE_HI`=10, `CHK_LO`=11.
  - `DEFAULT_STABLE_CYCLES` = 8.
- **Sub-module `sync_2ff`:** 1-bit two-flop synchroniser with the same `clk`/`reset`, parameterised by reset value.
- **Top:** instantiates `sync_2ff`, the FSM and the counter. Target size is roughly 150–200 lines.

## Test plan
All scenarios use STABLE_CYCLES=8 and RESET_VAL=0.
- **Reset:** hold `reset`=0 for 3 cycles, with `din_raw` toggling randomly. Required: `d_out`=0, `rise`=`fall`=`busy`=0 throughout. Then release `reset` with `din_raw`=0. Required: no pulse.
- **Clean rise:** `din_raw` 0→1 and held. Required: `busy` rises after edge 3, `d_out`=1 and `rise`=1 for one cycle after edge 10, `busy`=0 after edge 10.
- **Glitch rejection:** `din_raw` high for 5 cycles, then low. Required: `busy` pulses, `d_out` stays 0, `rise` is never asserted.
- **Bounce then settle:** pattern 1,0,1,1,0, then 1 held. Required: exactly one `rise`, 8 edges after the final settle reaches `s1`.
- **Clean fall:** from `d_out`=1, `din_raw` 1→0 and held. Required: `fall`=1 for one cycle, `d_out`=0 after edge 10, and `rise` stays 0.
- **Reset mid-qualification:** assert `reset` when `cnt`=5 in `CHK_HI`. Required: immediate `d_out`=0, `busy`=0, and no `rise` after release while `din_raw` is low.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the d-input debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    CHK_HI  = 2'b01,
    IDLE_HI = 2'b10,
    CHK_LO  = 2'b11
  } dbnc_state_t;

  localparam int DEFAULT_STABLE_CYCLES = 8;
  localparam int DEFAULT_CNT_W         = 4;

endpackage

// File: rtl/d_input_debouncer_sync.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic s0;
  logic s1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0 <= RESET_VAL;
      s1 <= RESET_VAL;
    end else begin
      s0 <= din;
      s1 <= s0;
    end
  end

  assign dout = s1;

endmodule

// File: rtl/d_input_debouncer.sv
// Debounces a raw asynchronous level: synchronise, qualify for STABLE_CYCLES
// consecutive samples, then present the level with one-cycle edge pulses.
module d_input_debouncer
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int   CNT_W         = DEFAULT_CNT_W,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din_raw,
  output logic d_out,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam dbnc_state_t      RESET_ST = RESET_VAL ? IDLE_HI : IDLE_LO;

  logic             s1;
  dbnc_state_t      state;
  dbnc_state_t      state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             d_next;
  logic             rise_next;
  logic             fall_next;

  sync_2ff #(
    .RESET_VAL(RESET_VAL)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .din  (din_raw),
    .dout (s1)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RESET_ST;
      cnt   <= '0;
      d_out <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      d_out <= d_next;
      rise  <= rise_next;
      fall  <= fall_next;
    end
  end

  // Any differing sample in a CHK state drops back to the originating IDLE,
  // so qualification always restarts from a count of one.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    d_next     = d_out;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state)
      IDLE_LO: begin
        if (s1) begin
          state_next = CHK_HI;
          cnt_next   = CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!s1) begin
          state_next = CHK_LO;
          cnt_next   = CNT_ONE;
        end
      end
      CHK_HI: begin
        if (!s1) begin
          state_next = IDLE_LO;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE_HI;
          d_next     = 1'b1;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      CHK_LO: begin
        if (s1) begin
          state_next = IDLE_HI;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE_LO;
          d_next     = 1'b0;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = RESET_ST;
      end
    endcase
  end

  assign busy = (state == CHK_HI) || (state == CHK_LO);

endmodule
